approx_mul_ha_array_pipe: RTL and testbench
===========================================

# approx_mul_ha_array_pipe

Parametrised, pipelined unsigned approximate multiplier built on half-adder row-pair arrays, with a valid/ready handshake. Each pair of partial-product rows is compressed into a t/b half-adder array. Half adders in columns below a configurable absolute weight are replaced by OR gates, so their carries are dropped. A per-transaction `exact` mode bypasses the approximation. A saturating counter records how many delivered results actually lost a carry. The block sits in the multiplier library as the sequential, width-generic successor to the fixed 8x8 combinational HA-array front ends.

## Interface
- `N`, 8: operand width; even, 4..32.
- `APPROX_W`, 4: approximate columns are those with absolute weight w < APPROX_W and w >= 1 that lie in array columns c >= 1; 0 gives an exact multiplier.
- `CNT_W`, 16: error counter width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept an operand pair this cycle.
- `x`  in  N  multiplicand.
- `y`  in  N  multiplier.
- `exact`  in  1  sampled with operands; 1 disables all OR approximation for that transaction.
- `out_valid`  out  1  `prod` valid.
- `out_ready`  in  1  consumer accepts.
- `prod`  out  2N  approximate (or exact) product.
- `err_cnt`  out  CNT_W  saturating count of delivered results that had at least one dropped carry.
- `clr_cnt`  in  1  synchronous clear of `err_cnt`.

## Operation
- Pair k (k = 0..N/2-1) uses rows x[2k] and x[2k+1].
  - pa[i] = y[i]&x[2k], relative weight i.
  - pb[i] = y[i]&x[2k+1], relative weight i+1.
- Column mapping within a pair:
  - Column 0: t[0] = pa[0].
  - Columns c = 1..N-1 combine pa[c] and pb[c-1].
  - HA column: t[c] = XOR of the two inputs; the carry goes to b[c-1], which has relative weight c+1.
  - OR column: t[c] = OR of the two inputs; b[c-1] = 0.
  - t[N] = carry of column N-1 (0 if that column is OR).
  - b[N-2] = pb[N-1].
- Column c is OR when `exact` = 0 and 2k+c < APPROX_W; otherwise it is HA.
- Pair value = T + (B << 2), where T is N+1 bits and B is N-1 bits. Product = sum over k of (pair value << 2k), truncated to 2N bits (no overflow is possible).
- Collision flag: set when any OR column has both inputs equal to 1. Such a result is low by 2^(2k+c) per collision.
- Pipeline stages:
  - S1 registers all t/b arrays plus the collision flag.
  - S2 registers `prod` and the flag.
- `err_cnt` increments by 1 on an output handshake (`out_valid`&`out_ready`) whose flag is set, and saturates at 2^CNT_W-1.
  - `clr_cnt` sets `err_cnt` to 0.
  - `clr_cnt` together with an incrementing handshake in the same cycle: clear wins, result 0.

## Timing
- Reset (asynchronous): S1/S2 valid = 0, `out_valid` = 0, `prod` = 0, `err_cnt` = 0. `in_ready` = 1 once reset is released.
- Latency: an operand accepted in cycle n shows `out_valid` = 1 in cycle n+2 if no stall occurs.
- Throughput: 1 transaction per cycle.
- Stall rules:
  - S2 loads when !S2_valid | `out_ready`.
  - S1 loads when !S1_valid | S2 loads.
  - `in_ready` = !S1_valid | S2 loads. This is a combinational path from `out_ready`.
- Acceptance requires `in_valid` & `in_ready`. `x`, `y` and `exact` are captured only in that cycle.
- While `out_valid` = 1 and `out_ready` = 0, `prod` and `out_valid` hold stable.
- Up to 2 transactions are buffered. Order is strictly preserved, and nothing is dropped or duplicated.
- Reset asserted mid-operation discards all in-flight transactions. No output is produced for them after release.

## Test plan
- N=8, APPROX_W=4, `exact`=1, x=0xFF, y=0xFF -> `prod` = 0xFE01 two cycles later; `err_cnt` stays 0.
- `exact`=0, x=3, y=3 -> `prod` = 7 (column 1 collision); `err_cnt` becomes 1 on the handshake. The same operands with `exact`=1 -> `prod` = 9, and `err_cnt` is unchanged.
- `exact`=0, x=0xF0, y=0x0F -> `prod` = 0x0E10 (exact); no collision is possible because all contributing weights are >= APPROX_W.
- Backpressure: hold `out_ready`=0 and offer 3 back-to-back ops (x=1,y=1; x=2,y=2; x=4,y=4), all with `exact`=1 -> only 2 are accepted and `in_ready` drops. Then raise `out_ready` -> outputs 1, 4, 16 appear in order, and the third op is accepted in the same cycle S2 frees.
- CNT_W=4: 20 colliding ops (x=3, y=3) -> `err_cnt` saturates at 15. Assert `clr_cnt` in the same cycle as another colliding handshake -> `err_cnt` = 0.
- Assert `rst` with 2 ops in flight -> `out_valid` goes to 0 immediately and `err_cnt` = 0. After release, no stale output appears and the next op returns its correct product after 2 cycles.

Source files
------------

// File: rtl/approx_mul_ha_array_pipe.sv
// Pipelined unsigned approximate multiplier: row pairs compressed by half-adder arrays,
// low-weight columns replaced by OR gates, with a saturating lost-carry counter.
module approx_mul_ha_array_pipe #(
   parameter int unsigned N        = 8,
   parameter int unsigned APPROX_W = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N-1:0]       x,
   input  logic [N-1:0]       y,
   input  logic               exact,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*N-1:0]     prod,
   output logic [CNT_W-1:0]   err_cnt,
   input  logic               clr_cnt
);

   localparam int unsigned NP  = N / 2;
   localparam int unsigned P_W = 2 * N;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NP-1:0][N:0]   w_t;
   logic [NP-1:0][N-2:0] w_b;
   logic                 w_coll;
   logic [NP-1:0][N:0]   r_t;
   logic [NP-1:0][N-2:0] r_b;
   logic                 r_s1_valid;
   logic                 r_s1_flag;
   logic [P_W-1:0]       w_sum;
   logic                 r_s2_valid;
   logic                 r_s2_flag;
   logic [P_W-1:0]       r_prod;
   logic [CNT_W-1:0]     r_cnt;
   logic                 w_s1_load;
   logic                 w_s2_load;
   logic                 w_accept;

   assign w_s2_load = !r_s2_valid | out_ready;
   assign w_s1_load = !r_s1_valid | w_s2_load;
   assign w_accept  = in_valid & w_s1_load;
   assign in_ready  = w_s1_load;
   assign out_valid = r_s2_valid;
   assign prod      = r_prod;
   assign err_cnt   = r_cnt;

   // Per-pair t/b compression; OR columns drop their carry and flag collisions
   always_comb begin
      logic w_pa;
      logic w_pb;
      w_t    = '0;
      w_b    = '0;
      w_coll = 1'b0;
      w_pa   = 1'b0;
      w_pb   = 1'b0;
      for (int k = 0; k < int'(NP); k++) begin
         w_t[k][0]   = y[0] & x[2*k];
         w_b[k][N-2] = y[N-1] & x[2*k+1];
         for (int c = 1; c < int'(N); c++) begin
            w_pa = y[c] & x[2*k];
            w_pb = y[c-1] & x[2*k+1];
            if (!exact && ((2*k + c) < int'(APPROX_W))) begin
               w_t[k][c] = w_pa | w_pb;
               if (w_pa & w_pb) w_coll = 1'b1;
            end else begin
               w_t[k][c] = w_pa ^ w_pb;
               if (c == int'(N) - 1) w_t[k][N]     = w_pa & w_pb;
               else                  w_b[k][c-1]   = w_pa & w_pb;
            end
         end
      end
   end

   // Final reduction of the registered pair arrays
   always_comb begin
      w_sum = '0;
      for (int k = 0; k < int'(NP); k++) begin
         w_sum = w_sum + (P_W'(r_t[k]) << (2*k)) + (P_W'(r_b[k]) << (2*k + 2));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_flag  <= 1'b0;
         r_t        <= '0;
         r_b        <= '0;
      end else if (w_s1_load) begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_t       <= w_t;
            r_b       <= w_b;
            r_s1_flag <= w_coll;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_flag  <= 1'b0;
         r_prod     <= '0;
      end else if (w_s2_load) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_prod    <= w_sum;
            r_s2_flag <= r_s1_flag;
         end
      end
   end

   // Clear has priority over a same-cycle increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr_cnt) begin
         r_cnt <= '0;
      end else if (r_s2_valid && out_ready && r_s2_flag && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_approx_mul_ha_array_pipe.sv
// Bench for approx_mul_ha_array_pipe: directed cases plus randomized traffic checked
// against an arithmetic model (exact product minus the weight of each OR collision).
module tb_approx_mul_ha_array_pipe;

   localparam int unsigned N  = 8;
   localparam int unsigned AW = 4;
   localparam int unsigned CW = 4;
   localparam int unsigned PW = 2 * N;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  x;
   logic [N-1:0]  y;
   logic          exact;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] prod;
   logic [CW-1:0] err_cnt;
   logic          clr_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   approx_mul_ha_array_pipe #(.N(N), .APPROX_W(AW), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .exact     (exact),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .prod      (prod),
      .err_cnt   (err_cnt),
      .clr_cnt   (clr_cnt)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Returns {collision_flag, product}
   function automatic logic [PW:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic e);
      logic [PW-1:0] p;
      logic          f;
      p = PW'(a) * PW'(b);
      f = 1'b0;
      if (!e) begin
         for (int k = 0; k < int'(N / 2); k++) begin
            for (int c = 1; c < int'(N); c++) begin
               if (((2*k + c) < int'(AW)) && a[2*k] && b[c] && a[2*k+1] && b[c-1]) begin
                  p = p - (PW'(1) << (2*k + c));
                  f = 1'b1;
               end
            end
         end
      end
      return {f, p};
   endfunction

   // Scoreboard and counter model, sampled on the falling edge
   logic [PW:0]   exp_q[$];
   logic [PW:0]   exp_item;
   logic [CW-1:0] m_cnt = '0;
   logic          held = 1'b0;
   logic [PW-1:0] held_prod = '0;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_cnt = '0;
         held  = 1'b0;
      end else begin
         check_eq("err_cnt", 64'(err_cnt), 64'(m_cnt));
         if (held) begin
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_prod", 64'(prod), 64'(held_prod));
         end
         held      = out_valid && !out_ready;
         held_prod = prod;
         if (out_valid && out_ready) begin
            check_eq("out_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               exp_item = exp_q.pop_front();
               check_eq("prod", 64'(prod), 64'(exp_item[PW-1:0]));
               if (clr_cnt) m_cnt = '0;
               else if (exp_item[PW] && (m_cnt != '1)) m_cnt = m_cnt + CW'(1);
            end else if (clr_cnt) begin
               m_cnt = '0;
            end
         end else if (clr_cnt) begin
            m_cnt = '0;
         end
         if (in_valid && in_ready) exp_q.push_back(ref_mul(x, y, exact));
      end
   end

   // Offer one op starting just after a rising edge; returns just after its accepting edge
   task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic e);
      logic acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      x        = a;
      y        = b;
      exact    = e;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check_eq("send_accept", 64'(acc), 64'd1);
   endtask

   initial begin
      in_valid  = 1'b0;
      x         = '0;
      y         = '0;
      exact     = 1'b0;
      out_ready = 1'b1;
      clr_cnt   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_prod", 64'(prod), 64'd0);
      check_eq("rst_err_cnt", 64'(err_cnt), 64'd0);
      rst = 1'b0;
      #1;
      check_eq("rst_in_ready", 64'(in_ready), 64'd1);

      // Exact mode, full-scale operands, two-cycle latency
      send(8'hFF, 8'hFF, 1'b1);
      check_eq("lat_early", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      check_eq("lat_valid", 64'(out_valid), 64'd1);
      check_eq("ff_exact", 64'(prod), 64'hFE01);
      @(posedge clk); #1;
      check_eq("ff_cnt", 64'(err_cnt), 64'd0);

      // Column-1 collision, then the same operands exact
      send(8'd3, 8'd3, 1'b0);
      @(posedge clk); #1;
      check_eq("c1_approx", 64'(prod), 64'd7);
      @(posedge clk); #1;
      check_eq("c1_cnt", 64'(err_cnt), 64'd1);
      send(8'd3, 8'd3, 1'b1);
      @(posedge clk); #1;
      check_eq("c1_exact", 64'(prod), 64'd9);
      @(posedge clk); #1;
      check_eq("c1_exact_cnt", 64'(err_cnt), 64'd1);

      // Only high-weight rows contribute: approximation cannot fire
      send(8'hF0, 8'h0F, 1'b0);
      @(posedge clk); #1;
      check_eq("hi_rows", 64'(prod), 64'h0E10);
      @(posedge clk); #1;
      check_eq("hi_rows_cnt", 64'(err_cnt), 64'd1);

      // Backpressure: two buffered, third waits for S2 to free
      out_ready = 1'b0;
      in_valid  = 1'b1; x = 8'd1; y = 8'd1; exact = 1'b1;
      @(negedge clk);
      check_eq("bp_rdy0", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      x = 8'd2; y = 8'd2;
      @(negedge clk);
      check_eq("bp_rdy1", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      x = 8'd4; y = 8'd4;
      @(negedge clk);
      check_eq("bp_full", 64'(in_ready), 64'd0);
      check_eq("bp_valid", 64'(out_valid), 64'd1);
      check_eq("bp_head", 64'(prod), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("bp_full2", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_release", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_eq("bp_out2", 64'(prod), 64'd4);
      @(posedge clk); #1;
      check_eq("bp_out3", 64'(prod), 64'd16);
      check_eq("bp_out3_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
      check_eq("bp_empty", 64'(out_valid), 64'd0);

      // Counter saturation, then clear against a colliding handshake
      for (int i = 0; i < 20; i++) send(8'd3, 8'd3, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check_eq("sat_cnt", 64'(err_cnt), 64'd15);
      send(8'd3, 8'd3, 1'b0);
      @(posedge clk); #1;
      check_eq("clr_valid", 64'(out_valid), 64'd1);
      clr_cnt = 1'b1;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
      check_eq("clr_wins", 64'(err_cnt), 64'd0);

      // Reset with two ops in flight
      send(8'd3, 8'd3, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_eq("pre_rst_cnt", 64'(err_cnt), 64'd1);
      out_ready = 1'b0;
      send(8'd3, 8'd3, 1'b0);
      send(8'd6, 8'd6, 1'b1);
      check_eq("pre_rst_valid", 64'(out_valid), 64'd1);
      rst = 1'b1;
      #1;
      check_eq("rst_async_valid", 64'(out_valid), 64'd0);
      check_eq("rst_async_cnt", 64'(err_cnt), 64'd0);
      @(posedge clk); #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check_eq("no_stale", 64'(out_valid), 64'd0);
      end
      send(8'hAB, 8'hCD, 1'b1);
      check_eq("post_rst_early", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      check_eq("post_rst_valid", 64'(out_valid), 64'd1);
      check_eq("post_rst_prod", 64'(prod), 64'h88EF);

      // Randomized traffic against the scoreboard
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 3) != 0);
         x         = N'($urandom);
         y         = N'($urandom);
         exact     = ($urandom_range(0, 3) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         clr_cnt   = ($urandom_range(0, 31) == 0);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      clr_cnt   = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      check_eq("drain", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
